// File: rtl/cic_pkg.sv
// Shared CIC helpers: width math, round-half-up shift and saturation.
// The decimator and integrator blocks reuse these helpers.
package cic_pkg;

   localparam int MAX_W = 64;

   typedef logic signed [MAX_W-1:0] wide_t;

   typedef struct packed {
      wide_t value;
      logic  sat;
   } sat_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r++;
      end
      return r;
   endfunction

   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : clog2(n);
   endfunction

   // Each comb stage grows the word by one bit, so this width never wraps.
   function automatic int int_w(input int dw, input int ns);
      return dw + ns;
   endfunction

   function automatic wide_t round_shift(input wide_t y, input int sh);
      wide_t half;
      if (sh <= 0) begin
         return y;
      end
      half = wide_t'(1) <<< (sh - 1);
      return (y + half) >>> sh;
   endfunction

   function automatic sat_t saturate(input wide_t r, input int ow);
      wide_t hi;
      wide_t lo;
      sat_t  res;
      hi        = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
      lo        = -(wide_t'(1) <<< (ow - 1));
      res.value = r;
      res.sat   = 1'b0;
      if (r > hi) begin
         res.value = hi;
         res.sat   = 1'b1;
      end else if (r < lo) begin
         res.value = lo;
         res.sat   = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/cic_comb_chain_stage.sv
// One comb stage: y = x - x*z^-M with a private M-deep delay line per channel,
// plus the valid/ch/bypass pipeline register.
module comb_stage
   import cic_pkg::*;
#(
   parameter int W      = 18,
   parameter int M      = 1,
   parameter int NUM_CH = 3,
   parameter int CH_W   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                clear,
   input  logic                in_valid,
   input  logic [CH_W-1:0]     in_ch,
   input  logic                in_byp,
   input  logic signed [W-1:0] in_data,
   output logic                out_valid,
   output logic [CH_W-1:0]     out_ch,
   output logic                out_byp,
   output logic signed [W-1:0] out_data
);

   logic                valid_q, valid_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                byp_q, byp_d;
   logic signed [W-1:0] data_q, data_d;
   logic signed [W-1:0] dly_q [NUM_CH][M];
   logic signed [W-1:0] dly_d [NUM_CH][M];

   always_comb begin
      valid_d = valid_q;
      ch_d    = ch_q;
      byp_d   = byp_q;
      data_d  = data_q;
      dly_d   = dly_q;
      if (en) begin
         valid_d = in_valid;
         if (in_valid) begin
            ch_d  = in_ch;
            byp_d = in_byp;
            if (in_byp) begin
               data_d = in_data;
            end else begin
               for (int c = 0; c < NUM_CH; c++) begin
                  if (in_ch == CH_W'(c)) begin
                     data_d      = in_data - dly_q[c][M-1];
                     dly_d[c][0] = in_data;
                     for (int k = 1; k < M; k++) begin
                        dly_d[c][k] = dly_q[c][k-1];
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         valid_q <= 1'b0;
         ch_q    <= '0;
         byp_q   <= 1'b0;
         data_q  <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < M; k++) begin
               dly_q[c][k] <= '0;
            end
         end
      end else begin
         valid_q <= valid_d;
         ch_q    <= ch_d;
         byp_q   <= byp_d;
         data_q  <= data_d;
         dly_q   <= dly_d;
      end
   end

   assign out_valid = valid_q;
   assign out_ch    = ch_q;
   assign out_byp   = byp_q;
   assign out_data  = data_q;

endmodule

// File: rtl/cic_comb_chain.sv
// Multi-stage, multi-channel TDM CIC comb section with rounding shift,
// saturation, bypass and synchronous clear.
module cic_comb_chain
   import cic_pkg::*;
#(
   parameter int  DATA_WIDTH = 16,
   parameter int  OUT_WIDTH  = 16,
   parameter int  NUM_STAGES = 2,
   parameter int  DIFF_DELAY = 1,
   parameter int  NUM_CH     = 3,
   parameter int  OUT_SHIFT  = 1,
   localparam int CH_W       = ch_w(NUM_CH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic                         clear,
   input  logic                         bypass,
   input  logic                         in_valid,
   input  logic [CH_W-1:0]              in_ch,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic                         out_valid,
   output logic [CH_W-1:0]              out_ch,
   output logic signed [OUT_WIDTH-1:0]  out_data,
   output logic                         out_sat,
   output logic                         err_ch
);

   localparam int             W        = int_w(DATA_WIDTH, NUM_STAGES);
   localparam logic [CH_W:0]  NUM_CH_L = (CH_W+1)'(NUM_CH);

   logic                st_valid [NUM_STAGES+1];
   logic [CH_W-1:0]     st_ch    [NUM_STAGES+1];
   logic                st_byp   [NUM_STAGES+1];
   logic signed [W-1:0] st_data  [NUM_STAGES+1];
   logic                ch_ok;
   logic                unused_byp;

   // Out-of-range channel tags never reach the delay lines.
   assign ch_ok       = ({1'b0, in_ch} < NUM_CH_L);
   assign st_valid[0] = in_valid & ch_ok;
   assign st_ch[0]    = in_ch;
   assign st_byp[0]   = bypass;
   assign st_data[0]  = W'(in_data);
   assign unused_byp  = st_byp[NUM_STAGES];

   for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      comb_stage #(
         .W      (W),
         .M      (DIFF_DELAY),
         .NUM_CH (NUM_CH),
         .CH_W   (CH_W)
      ) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (en),
         .clear     (clear),
         .in_valid  (st_valid[s]),
         .in_ch     (st_ch[s]),
         .in_byp    (st_byp[s]),
         .in_data   (st_data[s]),
         .out_valid (st_valid[s+1]),
         .out_ch    (st_ch[s+1]),
         .out_byp   (st_byp[s+1]),
         .out_data  (st_data[s+1])
      );
   end

   logic                        out_valid_q, out_valid_d;
   logic [CH_W-1:0]             out_ch_q, out_ch_d;
   logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic                        out_sat_q, out_sat_d;
   logic                        err_ch_q, err_ch_d;
   sat_t                        scaled;

   always_comb begin
      scaled      = saturate(round_shift(wide_t'(st_data[NUM_STAGES]), OUT_SHIFT), OUT_WIDTH);
      out_valid_d = out_valid_q;
      out_ch_d    = out_ch_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      err_ch_d    = err_ch_q;
      if (en) begin
         out_valid_d = st_valid[NUM_STAGES];
         out_sat_d   = 1'b0;
         err_ch_d    = in_valid & ~ch_ok;
         if (st_valid[NUM_STAGES]) begin
            out_ch_d   = st_ch[NUM_STAGES];
            out_data_d = OUT_WIDTH'(scaled.value);
            out_sat_d  = scaled.sat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         err_ch_q    <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         err_ch_q    <= err_ch_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign err_ch    = err_ch_q;

endmodule

// File: tb/tb_cic_comb_chain.sv
// Directed bench for cic_comb_chain at default parameters: per-cycle vector
// table plus hand sequences for clear, reset, bypass and enable stalls.
module tb_cic_comb_chain;

   logic               clk;
   logic               rst_n;
   logic               en;
   logic               clear;
   logic               bypass;
   logic               in_valid;
   logic [1:0]         in_ch;
   logic signed [15:0] in_data;
   logic               out_valid;
   logic [1:0]         out_ch;
   logic signed [15:0] out_data;
   logic               out_sat;
   logic               err_ch;

   int total;
   int bad;

   cic_comb_chain #(
      .DATA_WIDTH (16),
      .OUT_WIDTH  (16),
      .NUM_STAGES (2),
      .DIFF_DELAY (1),
      .NUM_CH     (3),
      .OUT_SHIFT  (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clear     (clear),
      .bypass    (bypass),
      .in_valid  (in_valid),
      .in_ch     (in_ch),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ch    (out_ch),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .err_ch    (err_ch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic               clr;
      logic               iv;
      logic [1:0]         ich;
      logic signed [15:0] idata;
      logic               ov;
      logic [1:0]         och;
      logic signed [15:0] od;
      logic               osat;
      logic               oerr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic clr, input logic iv, input logic [1:0] ich,
                               input logic signed [15:0] idata, input logic ov,
                               input logic [1:0] och, input logic signed [15:0] od,
                               input logic osat, input logic oerr);
      vec_t v;
      v.clr = clr; v.iv = iv; v.ich = ich; v.idata = idata;
      v.ov = ov; v.och = och; v.od = od; v.osat = osat; v.oerr = oerr;
      return v;
   endfunction

   // Drive one cycle of inputs, take the edge, then sample 1 ns later.
   task automatic cyc(input logic e, input logic r, input logic c, input logic b,
                      input logic v, input logic [1:0] ch, input logic signed [15:0] d);
      en = e; rst_n = r; clear = c; bypass = b; in_valid = v; in_ch = ch; in_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic ov, input logic [1:0] och,
                      input logic signed [15:0] od, input logic osat, input logic oerr);
      total++;
      if (out_valid !== ov) begin
         bad++;
         $display("FAIL %s out_valid got %0b want %0b", nm, out_valid, ov);
      end
      total++;
      if (err_ch !== oerr) begin
         bad++;
         $display("FAIL %s err_ch got %0b want %0b", nm, err_ch, oerr);
      end
      if (ov) begin
         total++;
         if (out_data !== od) begin
            bad++;
            $display("FAIL %s out_data got %0d want %0d", nm, out_data, od);
         end
         total++;
         if (out_ch !== och) begin
            bad++;
            $display("FAIL %s out_ch got %0d want %0d", nm, out_ch, och);
         end
         total++;
         if (out_sat !== osat) begin
            bad++;
            $display("FAIL %s out_sat got %0b want %0b", nm, out_sat, osat);
         end
      end
   endtask

   task automatic chk_data(input string nm, input logic signed [15:0] od);
      total++;
      if (out_data !== od) begin
         bad++;
         $display("FAIL %s out_data got %0d want %0d", nm, out_data, od);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // impulse on ch0
      tbl.push_back(mk(1, 0, 0,      0, 0, 0,      0, 0, 0));
      tbl.push_back(mk(0, 1, 0,    100, 0, 0,      0, 0, 0));
      tbl.push_back(mk(0, 1, 0,      0, 0, 0,      0, 0, 0));
      tbl.push_back(mk(0, 1, 0,      0, 1, 0,     50, 0, 0));
      tbl.push_back(mk(0, 1, 0,      0, 1, 0,   -100, 0, 0));
      tbl.push_back(mk(0, 0, 0,      0, 1, 0,     50, 0, 0));
      tbl.push_back(mk(0, 0, 0,      0, 1, 0,      0, 0, 0));
      tbl.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0, 0));
      // ch0 impulse interleaved with ch1 constant
      tbl.push_back(mk(0, 1, 0,    100, 0, 0,      0, 0, 0));
      tbl.push_back(mk(0, 1, 1,     40, 0, 0,      0, 0, 0));
      tbl.push_back(mk(0, 1, 0,      0, 1, 0,     50, 0, 0));
      tbl.push_back(mk(0, 1, 1,     40, 1, 1,     20, 0, 0));
      tbl.push_back(mk(0, 1, 0,      0, 1, 0,   -100, 0, 0));
      tbl.push_back(mk(0, 1, 1,     40, 1, 1,    -20, 0, 0));
      tbl.push_back(mk(0, 1, 0,      0, 1, 0,     50, 0, 0));
      tbl.push_back(mk(0, 1, 1,     40, 1, 1,      0, 0, 0));
      tbl.push_back(mk(0, 0, 0,      0, 1, 0,      0, 0, 0));
      tbl.push_back(mk(0, 0, 0,      0, 1, 1,      0, 0, 0));
      tbl.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0, 0));
      // full-scale alternation, saturation
      tbl.push_back(mk(0, 1, 0,  32767, 0, 0,      0, 0, 0));
      tbl.push_back(mk(0, 1, 0, -32768, 0, 0,      0, 0, 0));
      tbl.push_back(mk(0, 1, 0,  32767, 1, 0,  16384, 0, 0));
      tbl.push_back(mk(0, 0, 0,      0, 1, 0, -32768, 1, 0));
      tbl.push_back(mk(0, 0, 0,      0, 1, 0,  32767, 1, 0));
      tbl.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0, 0));
      // clear (sample discarded), bad channel, then impulse
      tbl.push_back(mk(1, 1, 0,   5000, 0, 0,      0, 0, 0));
      tbl.push_back(mk(0, 1, 3,    777, 0, 0,      0, 0, 1));
      tbl.push_back(mk(0, 1, 0,    100, 0, 0,      0, 0, 0));
      tbl.push_back(mk(0, 1, 0,      0, 0, 0,      0, 0, 0));
      tbl.push_back(mk(0, 1, 0,      0, 1, 0,     50, 0, 0));
      tbl.push_back(mk(0, 0, 0,      0, 1, 0,   -100, 0, 0));
      tbl.push_back(mk(0, 0, 0,      0, 1, 0,     50, 0, 0));
      tbl.push_back(mk(0, 0, 0,      0, 0, 0,      0, 0, 0));

      en = 1'b0; rst_n = 1'b0; clear = 1'b0; bypass = 1'b0;
      in_valid = 1'b0; in_ch = '0; in_data = '0;
      cyc(1, 0, 0, 0, 1, 0, 1234);
      cyc(1, 0, 0, 0, 1, 0, 1234);
      chk("reset", 0, 0, 0, 0, 0);
      chk_data("reset_data", 0);
      total++;
      if (out_sat !== 1'b0 || out_ch !== 2'd0) begin
         bad++;
         $display("FAIL reset_sat_ch got sat=%0b ch=%0d want 0 0", out_sat, out_ch);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(1, 1, tbl[i].clr, 0, tbl[i].iv, tbl[i].ich, tbl[i].idata);
         chk($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].och, tbl[i].od, tbl[i].osat, tbl[i].oerr);
      end

      // clear mid-stream flushes in-flight samples and delay lines
      cyc(1, 1, 0, 0, 1, 0, 1000); chk("t5_a", 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 0, 1000); chk("t5_b", 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 0, 1, 0, 1000); chk("t5_clr", 0, 0, 0, 0, 0);
      chk_data("t5_clr_data", 0);
      cyc(1, 1, 0, 0, 0, 0, 0);    chk("t5_flush1", 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);    chk("t5_flush2", 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 0, 1000); chk("t5_c", 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);    chk("t5_post_clr", 1, 0, 500, 0, 0);

      // reset mid-stream
      cyc(1, 1, 1, 0, 0, 0, 0);    chk("t5_clr2", 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 0, 1000);
      cyc(1, 1, 0, 0, 1, 0, 1000);
      cyc(1, 1, 0, 0, 1, 0, 1000); chk("t5_pre_rst", 1, 0, 500, 0, 0);
      cyc(1, 0, 0, 0, 1, 0, 1000); chk("t5_rst", 0, 0, 0, 0, 0);
      chk_data("t5_rst_data", 0);
      cyc(1, 1, 0, 0, 0, 0, 0);    chk("t5_rflush1", 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);    chk("t5_rflush2", 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 0, 1000);
      cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);    chk("t5_post_rst", 1, 0, 500, 0, 0);

      // bypass then normal impulse, with a 2-cycle enable stall
      cyc(1, 1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 1, 0, 300);  chk("t6_b1", 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 1, 0, -301); chk("t6_b2", 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 0, 100);  chk("t6_byp_pos", 1, 0, 150, 0, 0);
      cyc(1, 1, 0, 0, 1, 0, 0);    chk("t6_byp_neg", 1, 0, -150, 0, 0);
      cyc(1, 1, 0, 0, 1, 0, 0);    chk("t6_imp0", 1, 0, 50, 0, 0);
      cyc(0, 1, 0, 0, 1, 0, 9999); chk("t6_stall1", 1, 0, 50, 0, 0);
      cyc(0, 1, 0, 0, 1, 3, 9999); chk("t6_stall2", 1, 0, 50, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);    chk("t6_imp1", 1, 0, -100, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);    chk("t6_imp2", 1, 0, 50, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);    chk("t6_idle", 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0, 0);    chk("t6_idle2", 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cic_comb_chain.md
Name: cic_comb_chain

Overview:
Parametrised multi-stage CIC comb section for the DFE filter array, following the integrator/decimator in the decimation chain.
- Computes N cascaded differences y = x − x·z^(−M) per channel on a time-division-multiplexed sample stream, at full internal precision.
- Provides rounding-shift scaling, saturation, per-channel state, bypass and synchronous clear.
- Successor to the single-stage, single-channel comb.

Parameters:
DATA_WIDTH, 16, input sample width (signed)
OUT_WIDTH, 16, output sample width (signed)
NUM_STAGES, 2, number of cascaded comb stages (1..6)
DIFF_DELAY, 1, differential delay M in samples of the same channel (1 or 2)
NUM_CH, 3, number of TDM channels (1..8)
OUT_SHIFT, 1, arithmetic right shift applied before saturation (0..NUM_STAGES+4)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
en  in  1  global advance enable; when 0 all state and outputs hold
clear  in  1  synchronous flush of delay lines and pipeline
bypass  in  1  1 = pass samples through without differencing
in_valid  in  1  input sample strobe
in_ch  in  CH_W=max(1,clog2(NUM_CH))  channel tag of input sample
in_data  in  DATA_WIDTH  signed input sample
out_valid  out  1  output sample strobe
out_ch  out  CH_W  channel tag of output sample
out_data  out  OUT_WIDTH  signed output sample
out_sat  out  1  saturation occurred on this output sample (qualified by out_valid)
err_ch  out  1  one-cycle pulse: input dropped, in_ch >= NUM_CH

Behaviour:
- Reset and priority:
  - One clock (clk). Reset rst_n is synchronous and active-low.
  - Priority: rst_n > clear > en.
  - Reset: all outputs 0, all delay-line entries 0, all pipeline valids 0.
- clear (when rst_n=1): same effect as reset in the same edge. The input sample presented on that edge is discarded.
- en=0: nothing updates; inputs are ignored. out_valid/out_sat/err_ch hold their current value, so the downstream must also qualify with en.
- Internal width W = DATA_WIDTH + NUM_STAGES. Input is sign-extended to W. Stage arithmetic is W-bit two's complement and is exact, with no wrap for any input.
- Stage s (1..NUM_STAGES), on a valid sample of channel c:
  - y_s = x_s − D_s[c][M−1].
  - Then D_s[c] shifts: D_s[c][0] ← x_s.
  - Channels never share state.
- Pipeline: one register per stage plus one output register. valid and ch tags travel with the data.
- Latency: out_valid asserts NUM_STAGES+1 edges after the edge sampling in_valid=1 (default 3). Throughput is one sample per enabled cycle. There is no backpressure.
- bypass: sampled with the sample at stage 1 and carried in the pipeline.
  - Bypassed samples are not differenced and do not update delay lines.
  - They keep the same latency and the same scaling/saturation.
  - Mode may change between any two samples without corrupting other samples.
- Output scaling: r = (y + 2^(OUT_SHIFT−1)) >>> OUT_SHIFT, i.e. round half up. With OUT_SHIFT=0, r = y.
- Saturation:
  - If r > 2^(OUT_WIDTH−1)−1 or r < −2^(OUT_WIDTH−1), clamp to the bound and set out_sat=1 for that sample.
  - Otherwise out_sat=0.
- in_valid=1 with in_ch >= NUM_CH: the sample is dropped with no state change. err_ch pulses on the next edge.
- out_valid, out_sat and err_ch are single-cycle pulses per event.
- out_data/out_ch hold their last value when out_valid=0.

Decomposition:
- Shared package cic_pkg:
  - clog2 helper.
  - CH_W and internal-width functions.
  - round_shift and saturate functions, reused by the decimator/integrator blocks.
- Sub-module comb_stage: one comb stage with width W, per-channel M-deep delay memory, and valid/ch/bypass pipeline register.
- Top level instantiates NUM_STAGES comb_stage instances via generate, plus the output scaler/saturator register.

Test Plan:
1. Defaults; ch0 impulse 100 then 0,0,0 → out_data 50, −100, 50, 0 on ch0, each 3 edges after input; out_sat=0.
2. Interleave ch0 impulse 100 and ch1 constant 40 → ch0 gives 50, −100, 50, 0; ch1 gives 20, −20, 0, 0; tags correct, no cross-channel leakage.
3. ch0 alternating 32767, −32768, 32767 → outputs 16384 (out_sat=0), −32768 (out_sat=1), 32767 (out_sat=1).
4. in_ch=3 with NUM_CH=3 → err_ch one-cycle pulse, no out_valid, subsequent ch0 impulse still yields 50, −100, 50.
5. ch0 constant 1000 for 2 samples, assert clear, then 1000 again → post-clear output 500 (as from zero state); repeat with rst_n low mid-stream → all outputs 0 next edge and same 500 response afterwards.
6. bypass=1 on ch0 samples 300, −301, then bypass=0 impulse 100 → 150, −150, then 50, −100, 50 (delay lines untouched); en=0 for 2 cycles mid-stream → outputs and timing stretch by exactly 2 edges.
